reg_file_nd: RTL
================

Name: reg_file_nd

Overview:
Parametrised multi-entry register bank, the next generation of the single-bit D flip-flop.
- Generalised to WIDTH bits × DEPTH entries, with one write port and two read ports (A, B).
- Adds: selectable read latency, write-to-read bypass, optional hardwired zero register, per-entry "written since reset" flags.
- Sits between the decode stage and the ALU4CPU datapath: operand source for the ALU, destination for ALU results.

Parameters:
WIDTH, 4, data bits per entry
DEPTH, 4, number of entries (need not be a power of 2; min 2)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
READ_LAT, 1, read latency in cycles: 0 = combinational, 1 = registered
BYPASS, 1, 1 = same-cycle write forwarded to read; 0 = read returns old value
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  input  1  rising-edge clock, sole clock
rst  input  1  synchronous, active-high reset
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
re  input  1  read enable (READ_LAT=1 only; ignored when READ_LAT=0)
ra_addr  input  ADDR_W  read port A address
rb_addr  input  ADDR_W  read port B address
ra_data  output  WIDTH  read port A data
rb_data  output  WIDTH  read port B data
wr_seen  output  DEPTH  bit i set once entry i has been written since reset

Behaviour:
Interface: one clock (clk); reset (rst) is synchronous and active-high.

Reset (rst=1 at a rising edge):
- All entries ← 0; wr_seen ← 0; registered ra_data/rb_data ← 0.
- rst has priority over we and re in the same cycle: the write is dropped, the read does not update.
- Reset mid-sequence: one rst cycle fully clears state; no partial writes survive.

Write:
- At a rising edge with we=1 and waddr<DEPTH: mem[waddr] ← wdata and wr_seen[waddr] ← 1.
- waddr≥DEPTH (non-power-of-2 DEPTH): write ignored, no flag change.
- ZERO_REG=1 and waddr=0: write ignored; wr_seen[0] stays 0.

Read, READ_LAT=0:
- ra_data = mem[ra_addr], combinational; same for B.
- Out-of-range address → 0. ZERO_REG=1 and address 0 → 0.
- BYPASS=1 and we=1 and waddr==ra_addr (valid, not zero-reg) → ra_data = wdata combinationally.
- BYPASS=0 → pre-write contents.

Read, READ_LAT=1:
- At a rising edge with re=1: ra_data ← selected value; with re=0: ra_data holds. Same for B.
- Selected value follows the same rules as READ_LAT=0 (range check, zero reg, bypass).
- BYPASS=1 collision: captures wdata (new value).
- BYPASS=0 collision: captures the old value.
- Latency is 1 cycle from address/re to data.

General rules:
- Ports A and B are independent; both may address the same entry, including the write target, simultaneously.
- No arithmetic; all data paths exactly WIDTH bits, no truncation or extension.
- wr_seen is sticky until rst.

Decomposition:
- Shared package (cpu_pkg): data width constant (WIDTH default 4), the READ_LAT_COMB/READ_LAT_REG constants, and the address-width helper function.
- Sub-module reg_file_rport: one read port (mux, range check, zero-reg mask, bypass compare, optional output register). Instantiated twice in reg_file_nd.
- Storage array, write logic and wr_seen stay in the top module.

Test Plan:
- Reset then read all entries (WIDTH=4, DEPTH=4, READ_LAT=1): after rst, re=1 on each address → ra_data=rb_data=4'h0; wr_seen=4'b0000.
- Write/readback: write 4'hA@1, 4'h5@2, then ra_addr=1, rb_addr=2, re=1 → one cycle later ra_data=4'hA, rb_data=4'h5; wr_seen=4'b0110. With re=0 on the next cycle and new addresses, outputs hold 4'hA/4'h5.
- Collision: mem[3]=4'h2, then we=1, waddr=3, wdata=4'hC, ra_addr=3, re=1 → BYPASS=1 gives ra_data=4'hC; BYPASS=0 gives 4'h2, then 4'hC on the next read.
- Zero register (ZERO_REG=1): write 4'hF@0 → read addr 0 returns 4'h0; wr_seen[0]=0.
- Reset priority: rst=1 and we=1 (4'h7@2) in the same cycle → mem[2]=0, wr_seen=0. Write, then rst, then read → 0.
- Non-power-of-2 (DEPTH=3, READ_LAT=0): write 4'h9@3 ignored. Read addr 3 → 4'h0; wr_seen=3'b000. Same-cycle write 4'h6@1 with ra_addr=1 → ra_data=4'h6 combinationally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the CPU datapath register blocks.
package cpu_pkg;

  // Default data width of one register entry.
  localparam int DATA_W = 4;

  // Read latency selections for register file read ports.
  localparam int READ_LAT_COMB = 0;
  localparam int READ_LAT_REG  = 1;

  // Address width needed to index 'depth' entries (never below one bit).
  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_rport.sv
// One read port of the register file: address decode, zero-register mask,
// write bypass and an optional output register.
module reg_file_rport
  import cpu_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int READ_LAT = READ_LAT_REG,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  mem [DEPTH],
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  data
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic             addr_ok;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] data_q;

  // An address is readable when it is in range and not the hardwired zero entry.
  always_comb begin
    addr_ok = ({1'b0, addr} < DEPTH_L);
    if ((ZERO_REG != 0) && (addr == '0)) begin
      addr_ok = 1'b0;
    end
  end

  // Pick stored data, or the in-flight write data when bypass is enabled.
  always_comb begin
    sel = '0;
    if (addr_ok) begin
      if ((BYPASS != 0) && we && (waddr == addr)) begin
        sel = wdata;
      end else begin
        sel = mem[addr];
      end
    end
  end

  // Output register, loaded only on read enable; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (re) begin
      data_q <= sel;
    end
  end

  // In the combinational configuration the register is bypassed and trims away.
  always_comb begin
    data = (READ_LAT == READ_LAT_COMB) ? sel : data_q;
  end

endmodule

// File: rtl/reg_file_nd.sv
// Parametrised register file: one write port, two read ports (A and B),
// optional zero register and per-entry written-since-reset flags.
module reg_file_nd
  import cpu_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int READ_LAT = READ_LAT_REG,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  ra_data,
  output logic [WIDTH-1:0]  rb_data,
  output logic [DEPTH-1:0]  wr_seen
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic             write_ok;

  // A write lands only for an in-range address that is not the zero register.
  always_comb begin
    write_ok = we && ({1'b0, waddr} < DEPTH_L);
    if ((ZERO_REG != 0) && (waddr == '0)) begin
      write_ok = 1'b0;
    end
  end

  // Storage and sticky written flags; reset wins over any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_seen <= '0;
    end else if (write_ok) begin
      mem[waddr]     <= wdata;
      wr_seen[waddr] <= 1'b1;
    end
  end

  reg_file_rport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .READ_LAT(READ_LAT), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) port_a (
    .clk(clk), .rst(rst), .re(re), .addr(ra_addr), .mem(mem),
    .we(we), .waddr(waddr), .wdata(wdata), .data(ra_data)
  );

  reg_file_rport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .READ_LAT(READ_LAT), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) port_b (
    .clk(clk), .rst(rst), .re(re), .addr(rb_addr), .mem(mem),
    .we(we), .waddr(waddr), .wdata(wdata), .data(rb_data)
  );

endmodule
